// File: rtl/vga_sync_receiver.sv
// VGA link sink: samples hsync/vsync/RGB, recovers active-area coordinates,
// measures line length and frame height, and tracks lock to the expected timing.
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_ACTIVE    = 480,
    parameter int SYNC_ACTIVE = 0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       iclock,
    input  logic       ireset_n,
    input  logic       ihsync,
    input  logic       ivsync,
    input  logic       ivga_r,
    input  logic       ivga_g,
    input  logic       ivga_b,
    output logic [9:0] ohcount,
    output logic [9:0] ovcount,
    output logic       opixel_valid,
    output logic [2:0] orgb,
    output logic [9:0] oline_len,
    output logic [9:0] oframe_lines,
    output logic       oframe_start,
    output logic       olocked,
    output logic       oerror
);

    localparam logic       SYNC_LVL  = (SYNC_ACTIVE != 0);
    localparam logic [9:0] CNT_MAX   = 10'h3FF;
    localparam logic [9:0] H_TOTAL_L = 10'(H_TOTAL);
    localparam logic [9:0] H_START   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END     = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] V_TOTAL_L = 10'(V_TOTAL);
    localparam logic [9:0] V_START   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END     = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [3:0] LOCK_L    = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [3:0] good_cnt, good_next;
    logic       err_next;

    logic       hs1, vs1, hs1_d, vs1_d;
    logic [2:0] rgb1;
    logic       hedge, vedge;

    logic [9:0] hcnt, hcnt_inc, hcnt_next;
    logic [9:0] lacc, lacc_inc, lacc_next;
    logic [9:0] vpos;
    logic       h_seen, line_flag;
    logic       line_mismatch, lacc_bad, frame_bad, in_window;

    // Stage 1: syncs and colour registered together so they stay aligned.
    always_ff @(posedge iclock or negedge ireset_n) begin
        if (!ireset_n) begin
            hs1   <= 1'b0;
            vs1   <= 1'b0;
            hs1_d <= 1'b0;
            vs1_d <= 1'b0;
            rgb1  <= 3'b000;
        end else begin
            hs1   <= ihsync;
            vs1   <= ivsync;
            hs1_d <= hs1;
            vs1_d <= vs1;
            rgb1  <= {ivga_r, ivga_g, ivga_b};
        end
    end

    assign hedge = (hs1 == SYNC_LVL) && (hs1_d != SYNC_LVL);
    assign vedge = (vs1 == SYNC_LVL) && (vs1_d != SYNC_LVL);

    // hcnt_next/lacc_next are the position of the pixel now in stage 1, so the
    // window decision lines up with rgb1 and the output latency stays at two clocks.
    always_comb begin
        hcnt_inc  = (hcnt == CNT_MAX) ? hcnt : hcnt + 10'd1;
        hcnt_next = hedge ? 10'd0 : hcnt_inc;
        lacc_inc  = (lacc == CNT_MAX) ? lacc : lacc + 10'd1;
        if (vedge)      lacc_next = {9'd0, hedge};
        else if (hedge) lacc_next = lacc_inc;
        else            lacc_next = lacc;
        vpos          = lacc_next - 10'd1;
        line_mismatch = hedge && h_seen && (hcnt_inc != H_TOTAL_L);
        lacc_bad      = (lacc != V_TOTAL_L);
        frame_bad     = line_flag || line_mismatch || lacc_bad;
        in_window     = olocked && (hcnt_next >= H_START) && (hcnt_next < H_END) &&
                        (lacc_next != 10'd0) && (vpos >= V_START) && (vpos < V_END);
    end

    always_ff @(posedge iclock or negedge ireset_n) begin
        if (!ireset_n) begin
            hcnt         <= 10'd0;
            lacc         <= 10'd0;
            h_seen       <= 1'b0;
            line_flag    <= 1'b0;
            oline_len    <= 10'd0;
            oframe_lines <= 10'd0;
            oframe_start <= 1'b0;
            oerror       <= 1'b0;
            opixel_valid <= 1'b0;
            ohcount      <= 10'd0;
            ovcount      <= 10'd0;
            orgb         <= 3'b000;
        end else begin
            hcnt <= hcnt_next;
            lacc <= lacc_next;
            if (hedge) begin
                h_seen <= 1'b1;
                if (h_seen) oline_len <= hcnt_inc;
            end
            if (vedge) oframe_lines <= lacc;
            if (vedge)              line_flag <= 1'b0;
            else if (line_mismatch) line_flag <= 1'b1;
            oframe_start <= vedge;
            oerror       <= err_next;
            opixel_valid <= in_window;
            ohcount      <= in_window ? hcnt_next - H_START : 10'd0;
            ovcount      <= in_window ? vpos - V_START : 10'd0;
            orgb         <= in_window ? rgb1 : 3'b000;
        end
    end

    always_ff @(posedge iclock or negedge ireset_n) begin
        if (!ireset_n) begin
            state    <= ST_IDLE;
            good_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
        end
    end

    // A saturated line counter means the link has gone quiet: drop silently.
    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        err_next   = 1'b0;
        if (hcnt == CNT_MAX) begin
            state_next = ST_IDLE;
            good_next  = 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (vedge) begin
                        state_next = ST_ACQ;
                        good_next  = 4'd0;
                    end
                end
                ST_ACQ: begin
                    if (vedge) begin
                        if (frame_bad) begin
                            good_next = 4'd0;
                            err_next  = 1'b1;
                        end else begin
                            good_next = good_cnt + 4'd1;
                            if (good_cnt + 4'd1 == LOCK_L) state_next = ST_LOCK;
                        end
                    end
                end
                ST_LOCK: begin
                    if (line_mismatch || (vedge && lacc_bad)) begin
                        state_next = ST_ACQ;
                        good_next  = 4'd0;
                        err_next   = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        olocked = (state == ST_LOCK);
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver: scaled-down timing, one active-low and one
// active-high instance fed the same stream, checked cycle by cycle against a model.
module tb_vga_sync_receiver;

  localparam int H_TOTAL = 40, H_SYNC = 4, H_BACK = 3, H_ACTIVE = 30;
  localparam int V_TOTAL = 12, V_SYNC = 2, V_BACK = 2, V_ACTIVE = 7;
  localparam int LOCK_FRAMES = 2;
  localparam int H_START = H_SYNC + H_BACK, V_START = V_SYNC + V_BACK;
  localparam int PH_IDLE = 0, PH_ACQ = 1, PH_LOCK = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic hs_n, vs_n, hs_p, vs_p;
  logic vga_r, vga_g, vga_b;

  logic [9:0] n_hcount, n_vcount, n_llen, n_flines;
  logic       n_valid, n_fstart, n_locked, n_error;
  logic [2:0] n_rgb;
  logic [9:0] p_hcount, p_vcount, p_llen, p_flines;
  logic       p_valid, p_fstart, p_locked, p_error;
  logic [2:0] p_rgb;

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;

  logic [46:0] exp_q[$];

  // model state
  int m_t, m_last_ref, m_lacc, m_phase, m_good, m_line_len, m_frame_lines;
  bit m_seen, m_prev_h, m_prev_v, m_flag;

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE),
    .SYNC_ACTIVE(0), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut_n (
    .iclock(clk), .ireset_n(rst_n), .ihsync(hs_n), .ivsync(vs_n),
    .ivga_r(vga_r), .ivga_g(vga_g), .ivga_b(vga_b),
    .ohcount(n_hcount), .ovcount(n_vcount), .opixel_valid(n_valid), .orgb(n_rgb),
    .oline_len(n_llen), .oframe_lines(n_flines), .oframe_start(n_fstart),
    .olocked(n_locked), .oerror(n_error)
  );

  vga_sync_receiver #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE),
    .SYNC_ACTIVE(1), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut_p (
    .iclock(clk), .ireset_n(rst_n), .ihsync(hs_p), .ivsync(vs_p),
    .ivga_r(vga_r), .ivga_g(vga_g), .ivga_b(vga_b),
    .ohcount(p_hcount), .ovcount(p_vcount), .opixel_valid(p_valid), .orgb(p_rgb),
    .oline_len(p_llen), .oframe_lines(p_flines), .oframe_start(p_fstart),
    .olocked(p_locked), .oerror(p_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, want %0d", tag, $time, got, want);
    end
  endtask

  function automatic int sat(input int a);
    return (a > 1023) ? 1023 : a;
  endfunction

  function automatic logic [46:0] pack(input int hc, input int vc, input bit v, input logic [2:0] rgb,
                                       input int ll, input int fl, input bit fs, input bit lk, input bit er);
    return {10'(hc), 10'(vc), v, rgb, 10'(ll), 10'(fl), fs, lk, er};
  endfunction

  task automatic check_set(input string who, input logic [9:0] hc, input logic [9:0] vc, input logic v,
                           input logic [2:0] rgb, input logic [9:0] ll, input logic [9:0] fl,
                           input logic fs, input logic lk, input logic er, input logic [46:0] e);
    check({who, ".hcount"},  hc,  e[46:37]);
    check({who, ".vcount"},  vc,  e[36:27]);
    check({who, ".valid"},   v,   e[26]);
    check({who, ".rgb"},     rgb, e[25:23]);
    check({who, ".linelen"}, ll,  e[22:13]);
    check({who, ".flines"},  fl,  e[12:3]);
    check({who, ".fstart"},  fs,  e[2]);
    check({who, ".locked"},  lk,  e[1]);
    check({who, ".error"},   er,  e[0]);
  endtask

  // After release the line counter has already advanced over two samples
  // (reset-level and the held idle input) before the first driven pixel.
  task automatic model_reset();
    m_t = 0; m_last_ref = -3; m_lacc = 0; m_phase = PH_IDLE; m_good = 0;
    m_line_len = 0; m_frame_lines = 0; m_seen = 0; m_prev_h = 0; m_prev_v = 0; m_flag = 0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  task automatic model_step(input bit h_act, input bit v_act, input logic [2:0] rgb);
    bit he, ve, mism, loss, bad, err, was_locked, win;
    int len, pos, old_lacc, vp;
    he = h_act && !m_prev_h;
    ve = v_act && !m_prev_v;
    m_prev_h = h_act;
    m_prev_v = v_act;
    loss = (sat(m_t - 1 - m_last_ref) == 1023);
    mism = 0;
    if (he) begin
      len = sat(m_t - m_last_ref);
      if (m_seen) begin
        m_line_len = len;
        mism = (len != H_TOTAL);
      end
      m_seen = 1;
      m_last_ref = m_t;
    end
    pos = sat(m_t - m_last_ref);
    old_lacc = m_lacc;
    if (ve) begin
      m_frame_lines = old_lacc;
      m_lacc = he ? 1 : 0;
    end else if (he) begin
      m_lacc = sat(m_lacc + 1);
    end
    bad = m_flag || mism || (old_lacc != V_TOTAL);
    was_locked = (m_phase == PH_LOCK);
    err = 0;
    if (loss) begin
      m_phase = PH_IDLE;
      m_good = 0;
    end else if (m_phase == PH_IDLE) begin
      if (ve) begin m_phase = PH_ACQ; m_good = 0; end
    end else if (m_phase == PH_ACQ) begin
      if (ve) begin
        if (bad) begin m_good = 0; err = 1; end
        else begin
          m_good++;
          if (m_good == LOCK_FRAMES) m_phase = PH_LOCK;
        end
      end
    end else begin
      if (mism || (ve && old_lacc != V_TOTAL)) begin m_phase = PH_ACQ; m_good = 0; err = 1; end
    end
    if (ve) m_flag = 0;
    else if (mism) m_flag = 1;
    vp = m_lacc - 1;
    win = was_locked && (m_lacc > 0) && (pos >= H_START) && (pos < H_START + H_ACTIVE) &&
          (vp >= V_START) && (vp < V_START + V_ACTIVE);
    exp_q.push_back(pack(win ? pos - H_START : 0, win ? vp - V_START : 0, win, win ? rgb : 3'b000,
                         m_line_len, m_frame_lines, ve, m_phase == PH_LOCK, err));
    m_t++;
  endtask

  task automatic set_inputs(input bit h_act, input bit v_act, input logic [2:0] rgb);
    hs_n = ~h_act; vs_n = ~v_act;
    hs_p = h_act;  vs_p = v_act;
    {vga_r, vga_g, vga_b} = rgb;
  endtask

  task automatic compare_outputs();
    logic [46:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_set("n", n_hcount, n_vcount, n_valid, n_rgb, n_llen, n_flines, n_fstart, n_locked, n_error, e);
      check_set("p", p_hcount, p_vcount, p_valid, p_rgb, p_llen, p_flines, p_fstart, p_locked, p_error, e);
      err_seen += int'(n_error);
    end
  endtask

  task automatic drive_cycle(input bit h_act, input bit v_act, input logic [2:0] rgb);
    @(negedge clk);
    compare_outputs();
    set_inputs(h_act, v_act, rgb);
    model_step(h_act, v_act, rgb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 3'b000);
  endtask

  task automatic drive_px(input int x, input int y);
    logic [2:0] c;
    c = 3'b000;
    if (x >= H_START && x < H_START + H_ACTIVE && y >= V_START && y < V_START + V_ACTIVE)
      c = (x == H_START && y == V_START) ? 3'b101 : 3'($urandom_range(0, 7));
    drive_cycle(x < H_SYNC, y < V_SYNC, c);
  endtask

  task automatic send_frame(input int n_lines, input int short_y, input int short_len);
    for (int y = 0; y < n_lines; y++) begin
      for (int x = 0; x < ((y == short_y) ? short_len : H_TOTAL); x++) drive_px(x, y);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_inputs(1'b0, 1'b0, 3'b000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(3 + int'($urandom_range(0, 4)));

    // nominal stream: lock on the third vsync edge
    repeat (4) send_frame(V_TOTAL, -1, 0);
    check("nom.locked", n_locked, 1);
    check("nom.flines", n_flines, V_TOTAL);
    check("nom.linelen", n_llen, H_TOTAL);

    // one short line: drop at the measurement, bad frame at its end, relock
    err_seen = 0;
    send_frame(V_TOTAL, V_START + int'($urandom_range(0, V_ACTIVE - 1)), H_TOTAL - 1);
    repeat (3) send_frame(V_TOTAL, -1, 0);
    check("short.errors", err_seen, 2);
    check("short.relock", n_locked, 1);

    // frame one line short
    err_seen = 0;
    send_frame(V_TOTAL - 1, -1, 0);
    repeat (3) send_frame(V_TOTAL, -1, 0);
    check("lines.errors", err_seen, 1);
    check("lines.relock", p_locked, 1);

    // sync loss
    err_seen = 0;
    idle(1100);
    check("loss.locked", n_locked, 0);
    check("loss.valid", n_valid, 0);
    check("loss.errors", err_seen, 0);

    // relock, then reset in the middle of an active line
    repeat (4) send_frame(V_TOTAL, -1, 0);
    for (int y = 0; y < V_START + 2; y++)
      for (int x = 0; x < H_TOTAL; x++) drive_px(x, y);
    for (int x = 0; x <= H_START + 5; x++) drive_px(x, V_START + 2);
    check("pre_rst.valid", n_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_set("rst_n", n_hcount, n_vcount, n_valid, n_rgb, n_llen, n_flines, n_fstart, n_locked, n_error, '0);
    check_set("rst_p", p_hcount, p_vcount, p_valid, p_rgb, p_llen, p_flines, p_fstart, p_locked, p_error, '0);
    set_inputs(1'b0, 1'b0, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(4);
    repeat (4) send_frame(V_TOTAL, -1, 0);
    check("after_rst.locked_n", n_locked, 1);
    check("after_rst.locked_p", p_locked, 1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
